module_b_responder: RTL and testbench
=====================================

# module_b_responder

Responder end of the A↔B link. It accepts request words that moduleA drives on `data_to_B` and buffers them in a small FIFO. For each request it produces one response word on `data_from_B`, which is a running modular sum of all requests since reset or the last clear. Both directions use a valid/ready handshake, and port widths follow the shared `config.vh` width macros.

## Interface
Parameters:
- `DATA_TO_B_BITWIDTH`, default 8. Request width. The top level overrides it from the `config.vh` macro of the same name.
- `DATA_FROM_B_BITWIDTH`, default 8. Response and accumulator width. Overridden from `config.vh`.
- `B_EXTRA_OUT_BITWIDTH`, default 8. Width of the response counter.
- `FIFO_DEPTH`, default 4. Request FIFO depth. Must be a power of 2, and at least 2.

Ports:
- Clocking: one clock, `clk`. Reset `rst` is asynchronous and active-high.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous active-high reset.
- `data_to_B`  in  DATA_TO_B_BITWIDTH  request payload from moduleA.
- `data_to_B_valid`  in  1  request valid.
- `data_to_B_ready`  out  1  FIFO can accept a request (not full).
- `data_from_B`  out  DATA_FROM_B_BITWIDTH  response payload to moduleA.
- `data_from_B_valid`  out  1  response valid.
- `data_from_B_ready`  in  1  moduleA accepts the response.
- `b_extra_in`  in  1  accumulator clear strobe.
- `b_extra_out`  out  B_EXTRA_OUT_BITWIDTH  count of completed responses, modulo 2^B_EXTRA_OUT_BITWIDTH.

## Operation
- **Push:** on `data_to_B_valid && data_to_B_ready` at an edge, the request is written at the FIFO write pointer.
  - `data_to_B_ready = !full`. It is registered-state based, with no combinational path from `data_from_B_ready`.
- **FSM states:** IDLE, LOAD, RESP.
  - IDLE: go to LOAD if the FIFO is non-empty, otherwise stay.
  - LOAD: pop the FIFO head and compute the sum. `data_from_B` gets the sum and `data_from_B_valid` gets 1. Go to RESP.
  - RESP: hold `data_from_B` and `data_from_B_valid` stable until `data_from_B_ready`. On that handshake, increment `b_extra_out` and clear valid. Go to LOAD if the FIFO is non-empty (counted after any same-cycle push is excluded), else go to IDLE.
- **Sum:** `sum = (acc + head) mod 2^DATA_FROM_B_BITWIDTH`, then `acc <= sum`.
  - `head` is zero-extended if narrower than `DATA_FROM_B_BITWIDTH`, and truncated to its low bits if wider.
- **Clear:** `b_extra_in` high at an edge.
  - Outside LOAD: `acc <= 0`.
  - In LOAD: the sum uses acc = 0, so both `acc` and the response equal `head`.
  - Clear never alters a response already held in RESP.
- **Simultaneous push and pop:** both take effect and the occupancy count is unchanged. When the FIFO is full, ready is low, so no push occurs.
- **Pointers:** log2(FIFO_DEPTH) bits, wrapping naturally. Occupancy uses log2(FIFO_DEPTH)+1 bits.
- **Counter:** `b_extra_out` wraps from all-ones to 0.
- **Reset mid-operation:** FIFO contents are discarded, a pending response is dropped, and the FSM returns to IDLE.

## Timing
- Reset values: `data_to_B_ready` = 1 (empty FIFO), `data_from_B_valid` = 0, `data_from_B` = 0, `b_extra_out` = 0. Also `acc` = 0, both pointers = 0, FSM = IDLE.
- Latency: a request accepted at edge N enters LOAD at edge N+1, and `data_from_B_valid` is high after edge N+2.
- Throughput: at most one response per 2 cycles (RESP→LOAD→RESP). The FIFO absorbs bursts of up to `FIFO_DEPTH` requests.
- Ready: `data_to_B_ready` deasserts in the cycle after the push that fills the FIFO. It reasserts in the cycle after the first pop from a full FIFO.
- Output stability: `data_from_B` must not change while `data_from_B_valid && !data_from_B_ready`.

## Test plan
- **Reset values:** assert `rst` asynchronously between edges -> all outputs take their reset values immediately. Release `rst`, idle 5 cycles -> `data_from_B_valid` stays 0 and `data_to_B_ready` stays 1.
- **Accumulation:** push 0x05, 0x10, 0xF0 with `data_from_B_ready` held at 1 -> responses 0x05, 0x15, 0x05 (wrap). `b_extra_out` = 3. First valid 2 cycles after the first push.
- **Backpressure:** hold `data_from_B_ready` = 0 and push 6 requests back-to-back -> ready drops after the 4th FIFO entry. The 5th request is pushed only after the first pop. `data_from_B` is stable while stalled. Releasing ready drains all 6 responses in order.
- **Clear:** push 0x03, then assert `b_extra_in` coincident with LOAD of the next request 0x07 -> response 0x07. A following 0x01 gives 0x08.
- **Simultaneous push/pop at full:** fill the FIFO, then pop with the push attempt still held -> occupancy stays consistent, with no loss or duplication across 3 pointer wraps (16 requests).
- **Reset mid-operation:** assert `rst` with 3 queued requests and a response held in RESP -> no response emitted after reset. The next request 0x02 yields 0x02 and `b_extra_out` = 1.

Source files
------------

// File: rtl/module_b_responder.sv
// rtl/module_b_responder.sv - responder end of the A<->B link
// Buffers requests in a FIFO and answers each with the running modular sum.
module module_b_responder #(
  parameter int DATA_TO_B_BITWIDTH   = 8,
  parameter int DATA_FROM_B_BITWIDTH = 8,
  parameter int B_EXTRA_OUT_BITWIDTH = 8,
  parameter int FIFO_DEPTH           = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [DATA_TO_B_BITWIDTH-1:0]   data_to_B,
  input  logic                            data_to_B_valid,
  output logic                            data_to_B_ready,
  output logic [DATA_FROM_B_BITWIDTH-1:0] data_from_B,
  output logic                            data_from_B_valid,
  input  logic                            data_from_B_ready,
  input  logic                            b_extra_in,
  output logic [B_EXTRA_OUT_BITWIDTH-1:0] b_extra_out
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, LOAD, RESP} state_t;

  state_t state, state_next;

  logic [DATA_TO_B_BITWIDTH-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]                wr_ptr, rd_ptr;
  logic [CNT_W-1:0]                count;
  logic [DATA_FROM_B_BITWIDTH-1:0] acc;
  logic [DATA_FROM_B_BITWIDTH-1:0] head_ext;
  logic [DATA_FROM_B_BITWIDTH-1:0] sum;
  logic [DATA_TO_B_BITWIDTH-1:0]   head;
  logic                            full, empty, push, pop, load, done;

  assign full            = (count == CNT_W'(FIFO_DEPTH));
  assign empty           = (count == '0);
  assign data_to_B_ready = !full;
  assign push            = data_to_B_valid && !full;
  assign head            = mem[rd_ptr];

  generate
    if (DATA_TO_B_BITWIDTH >= DATA_FROM_B_BITWIDTH) begin : g_trunc
      assign head_ext = head[DATA_FROM_B_BITWIDTH-1:0];
    end else begin : g_zext
      assign head_ext = {{(DATA_FROM_B_BITWIDTH-DATA_TO_B_BITWIDTH){1'b0}}, head};
    end
  endgenerate

  // A clear coinciding with LOAD makes the response equal the head alone.
  assign sum = (b_extra_in ? '0 : acc) + head_ext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!empty) state_next = LOAD;
      LOAD:    state_next = RESP;
      RESP:    if (data_from_B_ready) state_next = empty ? IDLE : LOAD;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    pop  = 1'b0;
    load = 1'b0;
    done = 1'b0;
    case (state)
      LOAD: begin
        pop  = 1'b1;
        load = 1'b1;
      end
      RESP:    done = data_from_B_ready;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_to_B;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc               <= '0;
      data_from_B       <= '0;
      data_from_B_valid <= 1'b0;
      b_extra_out       <= '0;
    end else begin
      if (load)            acc <= sum;
      else if (b_extra_in) acc <= '0;
      if (load) begin
        data_from_B       <= sum;
        data_from_B_valid <= 1'b1;
      end else if (done) begin
        data_from_B_valid <= 1'b0;
      end
      if (done) b_extra_out <= b_extra_out + B_EXTRA_OUT_BITWIDTH'(1);
    end
  end

endmodule

// File: tb/tb_module_b_responder.sv
// tb/tb_module_b_responder.sv - self-checking bench for module_b_responder
// Table vectors, hand sequences and randomized traffic against a sum/queue model.
module tb_module_b_responder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] data_to_B = '0;
  logic       data_to_B_valid = 1'b0;
  logic       data_to_B_ready;
  logic [7:0] data_from_B;
  logic       data_from_B_valid;
  logic       data_from_B_ready = 1'b0;
  logic       b_extra_in = 1'b0;
  logic [7:0] b_extra_out;

  module_b_responder #(
    .DATA_TO_B_BITWIDTH(8), .DATA_FROM_B_BITWIDTH(8),
    .B_EXTRA_OUT_BITWIDTH(8), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst),
    .data_to_B(data_to_B), .data_to_B_valid(data_to_B_valid), .data_to_B_ready(data_to_B_ready),
    .data_from_B(data_from_B), .data_from_B_valid(data_from_B_valid), .data_from_B_ready(data_from_B_ready),
    .b_extra_in(b_extra_in), .b_extra_out(b_extra_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: expected responses in order, running sum, response count.
  int q[$];
  int m_acc = 0;
  int m_cnt = 0;
  int sent = 0;
  int target = 0;
  int last_resp = -1;

  typedef struct {
    logic [7:0] req;
    bit         clr_at_load;
    logic [7:0] exp_resp;
    logic [7:0] exp_cnt;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    data_to_B_valid   = 1'b0;
    data_from_B_ready = 1'b0;
    b_extra_in        = 1'b0;
    data_to_B         = '0;
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("rst_valid", data_from_B_valid, 0);
    check("rst_data", data_from_B, 0);
    check("rst_ready", data_to_B_ready, 1);
    check("rst_count", b_extra_out, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    q.delete();
    m_acc = 0; m_cnt = 0; sent = 0; target = 0;
  endtask

  // One clock with scoreboard bookkeeping; inputs must already be set.
  task automatic cycle();
    bit push, pop, stall;
    logic [7:0] held;
    push  = data_to_B_valid && data_to_B_ready;
    pop   = data_from_B_valid && data_from_B_ready;
    stall = data_from_B_valid && !data_from_B_ready;
    held  = data_from_B;
    if (pop) begin
      if (q.size() == 0) begin
        checks++; failures++;
        $display("FAIL spurious_resp: got 0x%0h expected no response", data_from_B);
      end else begin
        check("resp_data", data_from_B, q.pop_front());
      end
      last_resp = data_from_B;
      m_cnt = (m_cnt + 1) % 256;
    end
    if (b_extra_in) m_acc = 0;
    if (push) begin
      m_acc = (m_acc + data_to_B) % 256;
      q.push_back(m_acc);
    end
    @(posedge clk);
    #1;
    if (stall) begin
      check("stall_valid", data_from_B_valid, 1);
      check("stall_data", data_from_B, held);
    end
    check("resp_count", b_extra_out, m_cnt);
  endtask

  // Drive requests until target is sent and all responses are drained, or max_cycles.
  task automatic drive(input int max_cycles, input int valid_pct, input int ready_pct,
                       input int clr_pct, input bit seq);
    int cyc = 0;
    bit p;
    while ((sent < target || q.size() > 0 || data_from_B_valid) && cyc < max_cycles) begin
      if (!data_to_B_valid && sent < target && $urandom_range(99) < valid_pct) begin
        data_to_B       = seq ? 8'(sent + 1) : 8'($urandom);
        data_to_B_valid = 1'b1;
      end
      data_from_B_ready = ($urandom_range(99) < ready_pct);
      b_extra_in = (q.size() == 0 && !data_from_B_valid && $urandom_range(99) < clr_pct);
      p = data_to_B_valid && data_to_B_ready;
      cycle();
      b_extra_in = 1'b0;
      if (p) begin
        data_to_B_valid = 1'b0;
        sent++;
      end
      cyc++;
    end
  endtask

  initial begin
    vecs[0] = '{8'h05, 1'b0, 8'h05, 8'd1};
    vecs[1] = '{8'h10, 1'b0, 8'h15, 8'd2};
    vecs[2] = '{8'hF0, 1'b0, 8'h05, 8'd3};
    vecs[3] = '{8'h03, 1'b0, 8'h08, 8'd4};
    vecs[4] = '{8'h07, 1'b1, 8'h07, 8'd5};
    vecs[5] = '{8'h01, 1'b0, 8'h08, 8'd6};

    // Reset values, then idle behaviour.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("idle_valid", data_from_B_valid, 0);
      check("idle_ready", data_to_B_ready, 1);
    end

    // Table: one request at a time, checking latency, sums, clear-in-LOAD and count.
    data_from_B_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      data_to_B = vecs[i].req; data_to_B_valid = 1'b1;
      @(posedge clk); #1;
      data_to_B_valid = 1'b0;
      check("lat_n0_valid", data_from_B_valid, 0);
      @(posedge clk); #1;
      check("lat_n1_valid", data_from_B_valid, 0);
      b_extra_in = vecs[i].clr_at_load;
      @(posedge clk); #1;
      b_extra_in = 1'b0;
      check("lat_n2_valid", data_from_B_valid, 1);
      check("vec_resp", data_from_B, vecs[i].exp_resp);
      @(posedge clk); #1;
      check("vec_done_valid", data_from_B_valid, 0);
      check("vec_count", b_extra_out, vecs[i].exp_cnt);
    end

    // Backpressure: 6 back-to-back with the consumer stalled, then drain.
    do_reset();
    target = 6;
    drive(8, 100, 0, 0, 1'b1);
    check("bp_sent", sent, 5);
    check("bp_ready_low", data_to_B_ready, 0);
    check("bp_held_data", data_from_B, 8'h01);
    drive(200, 100, 100, 0, 1'b1);
    check("bp_all_sent", sent, 6);
    check("bp_drained", q.size(), 0);
    check("bp_last", last_resp, 21);
    check("bp_count", b_extra_out, 6);

    // Full FIFO with push held while popping: 16 requests, several pointer wraps.
    do_reset();
    target = 16;
    drive(8, 100, 0, 0, 1'b1);
    check("full_ready_low", data_to_B_ready, 0);
    drive(400, 100, 100, 0, 1'b1);
    check("full_sent", sent, 16);
    check("full_drained", q.size(), 0);
    check("full_count", b_extra_out, 16);
    check("full_last", last_resp, 136);

    // Reset mid-operation with queued requests and a held response.
    do_reset();
    target = 4;
    drive(10, 100, 0, 0, 1'b1);
    check("mid_valid_held", data_from_B_valid, 1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valid", data_from_B_valid, 0);
    check("mid_rst_ready", data_to_B_ready, 1);
    check("mid_rst_count", b_extra_out, 0);
    data_to_B_valid = 1'b0;
    q.delete(); m_acc = 0; m_cnt = 0; sent = 0; target = 0;
    @(posedge clk); #1 rst = 1'b0;
    data_from_B_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("mid_no_resp", data_from_B_valid, 0);
    end
    target = 1;
    data_to_B = 8'h02; data_to_B_valid = 1'b1;
    drive(50, 100, 100, 0, 1'b0);
    check("mid_next_resp", last_resp, 2);
    check("mid_next_count", b_extra_out, 1);

    // Randomized traffic with idle-time clears; long enough to wrap the counter.
    do_reset();
    target = 300;
    drive(6000, 70, 60, 20, 1'b0);
    check("rand_sent", sent, 300);
    check("rand_drained", q.size(), 0);
    check("rand_count", b_extra_out, 300 % 256);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
